// File: rtl/hmem_responder_if.sv
// ============================================================================
// hmem_responder_pkg / hmem_if : request operation encoding and the
// word-per-handshake request bus between the cache controller and memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hmem_responder_pkg;
    typedef enum logic [1:0] {
        LOAD       = 2'd0,
        STORE      = 2'd1,
        CLFLUSH    = 2'd2,
        MO_UNKNOWN = 2'd3
    } memory_operation_e;
endpackage

interface hmem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
);
    import hmem_responder_pkg::*;

    logic                  req_valid;
    memory_operation_e     req_operation;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [WORD_WIDTH-1:0] req_store_word;
    logic [WORD_WIDTH-1:0] req_loaded_word;
    logic                  req_fulfilled;

    modport master (
        output req_valid, req_operation, req_address, req_store_word,
        input  req_loaded_word, req_fulfilled
    );

    modport slave (
        input  req_valid, req_operation, req_address, req_store_word,
        output req_loaded_word, req_fulfilled
    );
endinterface

`default_nettype wire

// File: rtl/hmem_responder.sv
// ============================================================================
// hmem_responder : fixed-latency word-addressed backing store answering
// hmem_if LOAD/STORE requests. Optional HMEM_RESPONDER_JITTER_EN adds 0-3
// LFSR-driven extra wait cycles per accepted request.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    hmem_if.slave     req_if,
    output logic      illegal_op
);
    import hmem_responder_pkg::*;

    localparam int OFF_W = $clog2(WORD_WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 4);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    memory_operation_e     op_q, op_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  illegal_q;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic                  fulfilled;
    logic [WORD_WIDTH-1:0] loaded_word;
    logic                  mem_we;
    logic                  illegal_set;
    logic [1:0]            extra_wait;
    logic                  unused_addr;

    // Only the word-index slice of the address matters; the rest wraps away.
    assign unused_addr = ^req_if.req_address;

`ifdef HMEM_RESPONDER_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign extra_wait = lfsr_q[1:0];
`else
    assign extra_wait = 2'd0;
`endif

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        idx_d       = idx_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        fulfilled   = 1'b0;
        loaded_word = '0;
        mem_we      = 1'b0;
        illegal_set = 1'b0;
`ifdef HMEM_RESPONDER_JITTER_EN
        lfsr_d      = lfsr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    idx_d      = req_if.req_address[OFF_W +: IDX_W];
                    op_d       = req_if.req_operation;
                    wdata_d    = req_if.req_store_word;
                    wait_cnt_d = CNT_W'(LATENCY - 1) + CNT_W'(extra_wait);
`ifdef HMEM_RESPONDER_JITTER_EN
                    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                    state_d    = (wait_cnt_d == '0) ? ST_RESPOND : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req_if.req_valid) begin
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                    if (wait_cnt_q == CNT_W'(1)) begin
                        state_d = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                fulfilled = 1'b1;
                if (op_q == LOAD) begin
                    loaded_word = mem_q[idx_q];
                end else if (op_q == STORE) begin
                    mem_we = 1'b1;
                end else begin
                    illegal_set = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = state_e'('x);
                wait_cnt_d  = 'x;
                fulfilled   = 1'bx;
                loaded_word = 'x;
                mem_we      = 1'bx;
                illegal_set = 1'bx;
            end
        endcase
        // A response cycle overlapped by reset is squashed entirely.
        if (rst) begin
            fulfilled   = 1'b0;
            loaded_word = '0;
            mem_we      = 1'b0;
            illegal_set = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            idx_q      <= '0;
            op_q       <= LOAD;
            wdata_q    <= '0;
            illegal_q  <= 1'b0;
`ifdef HMEM_RESPONDER_JITTER_EN
            lfsr_q     <= 8'hA5;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            illegal_q  <= illegal_q | illegal_set;
`ifdef HMEM_RESPONDER_JITTER_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign req_if.req_fulfilled   = fulfilled;
    assign req_if.req_loaded_word = loaded_word;
    assign illegal_op             = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_hmem_responder.sv
// ============================================================================
// tb_hmem_responder : directed self-checking bench for hmem_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hmem_responder;
    import hmem_responder_pkg::*;

    localparam int AW    = 32;
    localparam int WW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic rst;
    logic illegal_op;

    always #5 clk = ~clk;

    hmem_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    hmem_responder #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_if    (bus),
        .illegal_op(illegal_op)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lat(input string tag, input int lat);
`ifdef HMEM_RESPONDER_JITTER_EN
        check_eq(tag, 64'((lat >= LAT) && (lat <= LAT + 3)), 64'd1);
`else
        check_eq(tag, 64'(lat), 64'(LAT));
`endif
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issues one request in an IDLE cycle; lat counts cycles from acceptance to the pulse.
    task automatic run_req(input memory_operation_e op, input logic [AW-1:0] addr,
                           input logic [WW-1:0] data, output int lat, output logic [WW-1:0] rd);
        bus.req_valid      = 1'b1;
        bus.req_operation  = op;
        bus.req_address    = addr;
        bus.req_store_word = data;
        lat = 0;
        while (!bus.req_fulfilled && lat < 40) begin
            tick();
            lat++;
        end
        rd = bus.req_loaded_word;
        bus.req_valid = 1'b0;
        tick();
    endtask

    int            lat;
    logic [WW-1:0] rd;
    int            n, cyc, prev, seen;
    int            lats_a [64];

    initial begin
        rst                = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_operation  = LOAD;
        bus.req_address    = '0;
        bus.req_store_word = '0;
        tick();
        tick();
        rst = 1'b0;

        check_eq("reset_fulfilled", 64'(bus.req_fulfilled), 64'd0);
        check_eq("reset_loaded", 64'(bus.req_loaded_word), 64'd0);
        check_eq("reset_illegal", 64'(illegal_op), 64'd0);

        run_req(STORE, 32'h40, 32'hDEADBEEF, lat, rd);
        check_lat("store_latency", lat);
        check_eq("store_illegal", 64'(illegal_op), 64'd0);
        run_req(LOAD, 32'h40, 32'h0, lat, rd);
        check_lat("load_latency", lat);
        check_eq("load_0x40", 64'(rd), 64'hDEADBEEF);

        run_req(STORE, 32'(DEPTH * 4 + 8), 32'h1234, lat, rd);
        run_req(LOAD, 32'h8, 32'h0, lat, rd);
        check_eq("wrap_load_0x8", 64'(rd), 64'h1234);
        run_req(LOAD, 32'h43, 32'h0, lat, rd);
        check_eq("byte_off_0x43", 64'(rd), 64'hDEADBEEF);

        for (int i = 0; i < 4; i++) begin
            run_req(STORE, 32'(32'h100 + 4 * i), 32'(32'h11110000 + i), lat, rd);
        end
        bus.req_valid     = 1'b1;
        bus.req_operation = LOAD;
        bus.req_address   = 32'h100;
        n = 0; cyc = 0; prev = 0;
        while (n < 4 && cyc < 100) begin
            if (bus.req_fulfilled) begin
                check_eq($sformatf("burst_data%0d", n), 64'(bus.req_loaded_word), 64'(32'h11110000 + n));
                if (n == 0) check_lat("burst_first", cyc);
                else        check_lat($sformatf("burst_gap%0d", n), cyc - prev - 1);
                prev = cyc;
                n++;
                bus.req_address = bus.req_address + 32'd4;
            end else if (cyc == 1) begin
                check_eq("loaded_zero_idle", 64'(bus.req_loaded_word), 64'd0);
            end
            if (n < 4) begin
                tick();
                cyc++;
            end
        end
        bus.req_valid = 1'b0;
        check_eq("burst_pulses", 64'(n), 64'd4);
        tick();

        run_req(STORE, 32'h20, 32'hAAAA, lat, rd);
        bus.req_valid      = 1'b1;
        bus.req_operation  = STORE;
        bus.req_address    = 32'h20;
        bus.req_store_word = 32'hFFFF;
        seen = 0;
        tick(); seen |= int'(bus.req_fulfilled);
        tick(); seen |= int'(bus.req_fulfilled);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= int'(bus.req_fulfilled);
        end
        check_eq("abort_no_pulse", 64'(seen), 64'd0);
        run_req(LOAD, 32'h20, 32'h0, lat, rd);
        check_eq("abort_mem_kept", 64'(rd), 64'hAAAA);

        bus.req_valid      = 1'b1;
        bus.req_operation  = STORE;
        bus.req_address    = 32'h20;
        bus.req_store_word = 32'h5555;
        n = 0;
        while (!bus.req_fulfilled && n < 40) begin
            tick();
            n++;
        end
        check_lat("rst_resp_reached", n);
        rst = 1'b1;
        #1;
        check_eq("rst_resp_no_pulse", 64'(bus.req_fulfilled), 64'd0);
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_resp_after", 64'(bus.req_fulfilled), 64'd0);
        tick();
        check_eq("rst_resp_idle", 64'(bus.req_fulfilled), 64'd0);
        run_req(LOAD, 32'h20, 32'h0, lat, rd);
        check_eq("rst_resp_no_write", 64'(rd), 64'hAAAA);
        check_lat("rst_then_load_lat", lat);

        run_req(CLFLUSH, 32'h40, 32'h0BAD, lat, rd);
        check_lat("clflush_latency", lat);
        check_eq("clflush_illegal", 64'(illegal_op), 64'd1);
        run_req(LOAD, 32'h40, 32'h0, lat, rd);
        check_eq("clflush_mem_kept", 64'(rd), 64'hDEADBEEF);
        check_eq("illegal_sticky", 64'(illegal_op), 64'd1);
        pulse_reset();
        check_eq("illegal_cleared", 64'(illegal_op), 64'd0);

`ifdef HMEM_RESPONDER_JITTER_EN
        for (int i = 0; i < 64; i++) begin
            run_req(LOAD, 32'h0, 32'h0, lat, rd);
            lats_a[i] = lat;
            check_lat($sformatf("jitter_range%0d", i), lat);
        end
        pulse_reset();
        for (int i = 0; i < 64; i++) begin
            run_req(LOAD, 32'h0, 32'h0, lat, rd);
            check_eq($sformatf("jitter_repeat%0d", i), 64'(lat), 64'(lats_a[i]));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
